ifetch_queue: RTL and testbench

- Fetch stage directly downstream of the program-counter register in the KGP-miniRISC core.
- Takes the current instruction address from the PC and issues in-order requests to instruction memory.
- Buffers returned words with their addresses in a small queue and hands them to decode over a valid/ready handshake.
- Back-pressures the PC through pc_stall and discards stale fetches on a redirect (branch/jump).

---
 rtl/kgp_minirisc_pkg.sv | 16 +
 rtl/ifq_slot_array.sv | 83 ++++++++
 rtl/ifetch_queue.sv | 110 +++++++++++
 tb/tb_ifetch_queue.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/kgp_minirisc_pkg.sv
// Shared KGP-miniRISC definitions: reset-PC sentinel, default widths and the
// fetch-queue slot state encoding.
package kgp_minirisc_pkg;

    localparam int ADDR_W_DEF  = 32;
    localparam int INSTR_W_DEF = 32;

    localparam logic [31:0] RESET_PC_SENTINEL = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        RESERVED = 2'd1,
        FILLED   = 2'd2
    } slot_state_t;

endpackage

// File: rtl/ifq_slot_array.sv
// Circular storage for the fetch queue: per-slot state, address and data with
// head (decode), tail (issue) and fill (oldest outstanding) pointers.
module ifq_slot_array
    import kgp_minirisc_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic                       fill_en,
    input  logic [INSTR_W-1:0]         fill_data,
    input  logic                       pop,
    output slot_state_t                head_state,
    output logic [ADDR_W-1:0]          head_addr,
    output logic [INSTR_W-1:0]         head_data,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic [$clog2(DEPTH):0]     reserved_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    slot_state_t          state_q [DEPTH];
    logic [ADDR_W-1:0]    addr_q  [DEPTH];
    logic [INSTR_W-1:0]   data_q  [DEPTH];
    logic [PW-1:0]        head_q, tail_q, fill_q;

    // Issue, fill and pop always touch three different slots (EMPTY, RESERVED,
    // FILLED respectively), so they can all land in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                state_q[i] <= EMPTY;
                addr_q[i]  <= '0;
                data_q[i]  <= '0;
            end
            head_q <= '0;
            tail_q <= '0;
            fill_q <= '0;
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                state_q[i] <= EMPTY;
            end
            head_q <= '0;
            tail_q <= '0;
            fill_q <= '0;
        end else begin
            if (wr_en) begin
                state_q[tail_q] <= RESERVED;
                addr_q[tail_q]  <= wr_addr;
                tail_q          <= tail_q + PW'(1);
            end
            if (fill_en) begin
                state_q[fill_q] <= FILLED;
                data_q[fill_q]  <= fill_data;
                fill_q          <= fill_q + PW'(1);
            end
            if (pop) begin
                state_q[head_q] <= EMPTY;
                head_q          <= head_q + PW'(1);
            end
        end
    end

    always_comb begin
        occupancy    = '0;
        reserved_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (state_q[i] != EMPTY)    occupancy    = occupancy + CW'(1);
            if (state_q[i] == RESERVED) reserved_cnt = reserved_cnt + CW'(1);
        end
    end

    assign head_state = state_q[head_q];
    assign head_addr  = addr_q[head_q];
    assign head_data  = data_q[head_q];

endmodule

// File: rtl/ifetch_queue.sv
// KGP-miniRISC fetch stage: issues in-order imem requests from the PC, queues
// returned words for decode and drops stale responses after a redirect.
// Optional performance counters are compiled in with IFQ_PERF_EN.
module ifetch_queue
    import kgp_minirisc_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  pc_addr,
    output logic               pc_stall,
    input  logic               flush,
    output logic               imem_req_valid,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_req_ready,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic               dec_valid,
    output logic [INSTR_W-1:0] dec_instr,
    output logic [ADDR_W-1:0]  dec_pc,
    input  logic               dec_ready
`ifdef IFQ_PERF_EN
    ,
    output logic [31:0]        perf_fetch_cnt,
    output logic [31:0]        perf_drop_cnt,
    output logic [31:0]        perf_stall_cnt
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int IW = CW + 1;

    logic [CW-1:0] drop_cnt, occupancy, reserved_cnt;
    logic [IW-1:0] inflight;
    slot_state_t   head_state;
    logic          sentinel, issue, pop, fill_en, rsp_live, rsp_dropped;

    assign sentinel = (pc_addr == RESET_PC_SENTINEL[ADDR_W-1:0]);

    // Dropped-but-outstanding responses also occupy memory capacity, so the
    // in-flight bound covers both; it implies occupancy < DEPTH.
    assign inflight       = IW'(occupancy) + IW'(drop_cnt);
    assign imem_req_valid = rst && !flush && !sentinel && (inflight < IW'(DEPTH));
    assign imem_req_addr  = pc_addr;
    assign issue          = imem_req_valid && imem_req_ready;
    assign pc_stall       = !rst || !(issue || flush || sentinel);

    assign dec_valid = (head_state == FILLED);
    assign pop       = dec_valid && dec_ready && !flush;

    assign rsp_live    = rst && imem_rsp_valid;
    assign fill_en     = rsp_live && !flush && (drop_cnt == '0) && (reserved_cnt != '0);
    assign rsp_dropped = rsp_live && ((drop_cnt != '0) || (flush && (reserved_cnt != '0)));

    ifq_slot_array #(
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_slots (
        .clk          (clk),
        .rst          (rst),
        .clear        (flush),
        .wr_en        (issue),
        .wr_addr      (pc_addr),
        .fill_en      (fill_en),
        .fill_data    (imem_rsp_data),
        .pop          (pop),
        .head_state   (head_state),
        .head_addr    (dec_pc),
        .head_data    (dec_instr),
        .occupancy    (occupancy),
        .reserved_cnt (reserved_cnt)
    );

    // On a flush every RESERVED slot becomes a response to discard; one that
    // arrives in the flush cycle itself is discarded immediately, hence the -1.
    always_ff @(posedge clk) begin
        if (!rst) begin
            drop_cnt <= '0;
        end else if (flush) begin
            drop_cnt <= drop_cnt + reserved_cnt - CW'(rsp_dropped);
        end else if (rsp_dropped) begin
            drop_cnt <= drop_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst && imem_rsp_valid) begin
            assert ((drop_cnt != '0) || (reserved_cnt != '0));
        end
    end

`ifdef IFQ_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_fetch_cnt <= '0;
            perf_drop_cnt  <= '0;
            perf_stall_cnt <= '0;
        end else begin
            perf_fetch_cnt <= perf_fetch_cnt + 32'(issue);
            perf_drop_cnt  <= perf_drop_cnt  + 32'(rsp_dropped);
            perf_stall_cnt <= perf_stall_cnt + 32'(pc_stall);
        end
    end
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Randomized self-checking bench for ifetch_queue: PC and in-order memory
// environment plus a queue-level reference model of the fetch buffer.
module tb_ifetch_queue;

    localparam int DEPTH = 4;
    localparam logic [31:0] SENT = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        rst, flush, imem_req_ready, imem_rsp_valid, dec_ready;
    logic [31:0] pc_addr, imem_rsp_data;
    logic        pc_stall, imem_req_valid, dec_valid;
    logic [31:0] imem_req_addr, dec_instr, dec_pc;
`ifdef IFQ_PERF_EN
    logic [31:0] perf_fetch_cnt, perf_drop_cnt, perf_stall_cnt;
`endif

    ifetch_queue #(.DEPTH(DEPTH), .ADDR_W(32), .INSTR_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_addr        (pc_addr),
        .pc_stall       (pc_stall),
        .flush          (flush),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .dec_valid      (dec_valid),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc),
        .dec_ready      (dec_ready)
`ifdef IFQ_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_drop_cnt  (perf_drop_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: queue of fetched entries in program order plus the
    // number of outstanding responses that must be thrown away.
    typedef struct { logic [31:0] addr; bit filled; logic [31:0] data; } ent_t;
    typedef struct { logic [31:0] addr; int due; } req_t;
    ent_t        mq[$];
    req_t        memq[$];
    int          mdrop, cyc, checks, errors, lat_min, lat_extra;
    int          pf_fetch, pf_drop, pf_stall;
    logic [31:0] pc_reg;
    logic [31:0] iss_log[$];
    int          iss_cyc[$];
    logic [31:0] deq_log[$];
    int          deq_cyc[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    function automatic int model_reserved();
        int n = 0;
        foreach (mq[i]) if (!mq[i].filled) n++;
        return n;
    endfunction

    function automatic bit rsp_next();
        return (memq.size() > 0) && (memq[0].due <= cyc);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    // One full clock cycle: drive inputs, check outputs against the model,
    // then advance model, memory and PC across the rising edge.
    task automatic applyStimulus(input bit r, input bit f, input logic [31:0] tgt,
                                 input bit rdy, input bit dr);
        bit          exp_rv, exp_issue, exp_stall, exp_dv, act_issue, act_stall, rspv;
        logic [31:0] req_a;
        int          n;
        ent_t        e;
        req_t        rq;
        @(negedge clk);
        rst = r; flush = f; imem_req_ready = rdy; dec_ready = dr; pc_addr = pc_reg;
        rspv = rsp_next();
        imem_rsp_valid = rspv;
        imem_rsp_data  = rspv ? mem_word(memq[0].addr) : $urandom;
        #1;
        exp_rv    = r && !f && (pc_reg != SENT) && (mq.size() + mdrop < DEPTH);
        exp_issue = exp_rv && rdy;
        exp_stall = !r || !(exp_issue || f || (pc_reg == SENT));
        exp_dv    = (mq.size() > 0) && mq[0].filled;
        checkOutput("req_valid", imem_req_valid, exp_rv);
        checkOutput("pc_stall", pc_stall, exp_stall);
        checkOutput("dec_valid", dec_valid, exp_dv);
        if (exp_rv) checkOutput("req_addr", imem_req_addr, pc_reg);
        if (exp_dv) begin
            checkOutput("dec_pc", dec_pc, mq[0].addr);
            checkOutput("dec_instr", dec_instr, mq[0].data);
        end
`ifdef IFQ_PERF_EN
        checkOutput("perf_fetch", perf_fetch_cnt, pf_fetch);
        checkOutput("perf_drop", perf_drop_cnt, pf_drop);
        checkOutput("perf_stall", perf_stall_cnt, pf_stall);
`endif
        act_issue = imem_req_valid && rdy;
        act_stall = pc_stall;
        req_a     = imem_req_addr;
        if (act_issue) begin iss_log.push_back(req_a); iss_cyc.push_back(cyc); end
        if (dec_valid && dr && !f) begin deq_log.push_back(dec_pc); deq_cyc.push_back(cyc); end
        @(posedge clk);
        if (!r) begin
            mq.delete(); memq.delete(); mdrop = 0; pc_reg = SENT;
            pf_fetch = 0; pf_drop = 0; pf_stall = 0;
        end else begin
            if (rspv) void'(memq.pop_front());
            if (act_issue) begin
                rq.addr = req_a;
                rq.due  = cyc + lat_min + $urandom_range(lat_extra, 0);
                memq.push_back(rq);
            end
            if (f) begin
                n = model_reserved();
                if (rspv) begin
                    if (mdrop > 0) begin mdrop--; pf_drop++; end
                    else if (n > 0) begin n--; pf_drop++; end
                end
                mdrop += n;
                mq.delete();
            end else begin
                if (rspv) begin
                    if (mdrop > 0) begin
                        mdrop--; pf_drop++;
                    end else begin
                        foreach (mq[i]) if (!mq[i].filled) begin
                            mq[i].filled = 1'b1;
                            mq[i].data   = imem_rsp_data;
                            break;
                        end
                    end
                end
                if (exp_dv && dr) void'(mq.pop_front());
                if (exp_issue) begin e.addr = pc_reg; e.filled = 1'b0; e.data = '0; mq.push_back(e); end
            end
            pf_fetch += int'(exp_issue);
            pf_stall += int'(exp_stall);
            if (f) pc_reg = tgt;
            else if (!act_stall) pc_reg = pc_reg + 32'd4;
        end
        cyc++;
    endtask

    task automatic startScenario(input int lmin, input int lext);
        lat_min = lmin; lat_extra = lext;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        iss_log.delete(); iss_cyc.delete(); deq_log.delete(); deq_cyc.delete();
    endtask

    initial begin
        bit found;
        checks = 0; errors = 0; cyc = 0; mdrop = 0;
        pf_fetch = 0; pf_drop = 0; pf_stall = 0;
        lat_min = 1; lat_extra = 0; pc_reg = SENT;
        rst = 1'b0; flush = 1'b0; imem_req_ready = 1'b0; dec_ready = 1'b0;
        imem_rsp_valid = 1'b0; imem_rsp_data = '0; pc_addr = SENT;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_dec_valid", dec_valid, 0);
        checkOutput("rst_dec_pc", dec_pc, 0);
        checkOutput("rst_dec_instr", dec_instr, 0);
        checkOutput("rst_req_valid", imem_req_valid, 0);
        checkOutput("rst_pc_stall", pc_stall, 1);

        // Latency 1, decode always ready: back-to-back fetch and decode.
        startScenario(1, 0);
        repeat (12) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("s1_iss_n", iss_log.size() >= 3, 1);
        checkOutput("s1_deq_n", deq_log.size() >= 3, 1);
        if (iss_log.size() >= 3 && deq_log.size() >= 3) begin
            for (int i = 0; i < 3; i++) begin
                checkOutput("s1_req_addr", iss_log[i], 32'(4 * i));
                checkOutput("s1_dec_pc", deq_log[i], 32'(4 * i));
            end
            checkOutput("s1_req_gap", iss_cyc[2] - iss_cyc[0], 2);
            checkOutput("s1_dec_gap", deq_cyc[2] - deq_cyc[0], 2);
        end

        // Decode stalled: queue fills to DEPTH and holds its head.
        startScenario(1, 0);
        repeat (12) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput("s2_issued", iss_log.size(), DEPTH);
        checkOutput("s2_hold_instr", dec_instr, mem_word(32'h0));
        repeat (12) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("s2_deq_n", deq_log.size() >= 4, 1);
        if (deq_log.size() >= 4)
            for (int i = 0; i < 4; i++) checkOutput("s2_drain_pc", deq_log[i], 32'(4 * i));

        // Latency 3, redirect with two outstanding requests.
        startScenario(3, 0);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (model_reserved() == 2 && mdrop == 0 && !rsp_next() && mq.size() == 2) begin
                found = 1'b1;
                deq_log.delete();
                applyStimulus(1'b1, 1'b1, 32'h100, 1'b1, 1'b1);
            end else begin
                applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
            end
        end
        checkOutput("s3_flush_reached", found, 1);
        repeat (20) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("s3_deq_n", deq_log.size() > 0, 1);
        if (deq_log.size() > 0) checkOutput("s3_first_pc", deq_log[0], 32'h100);
`ifdef IFQ_PERF_EN
        checkOutput("s3_perf_drop", perf_drop_cnt, 2);
        checkOutput("s3_perf_fetch", perf_fetch_cnt, pf_fetch);
`endif

        // Redirect in the same cycle as a response for a reserved slot.
        startScenario(2, 0);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (model_reserved() > 0 && mdrop == 0 && rsp_next() && i > 4) begin
                found = 1'b1;
                deq_log.delete();
                applyStimulus(1'b1, 1'b1, 32'h200, 1'b1, 1'b1);
                #1;
                checkOutput("s4_no_stale", dec_valid, 0);
            end else begin
                applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
            end
        end
        checkOutput("s4_flush_reached", found, 1);
        repeat (20) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("s4_deq_n", deq_log.size() > 0, 1);
        if (deq_log.size() > 0) checkOutput("s4_first_pc", deq_log[0], 32'h200);

        // One-cycle reset with three entries queued, then restart.
        startScenario(2, 2);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (mq.size() == 3) begin
                found = 1'b1;
                applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
                #1;
                checkOutput("s5_dec_valid", dec_valid, 0);
                iss_log.delete();
            end else begin
                applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
            end
        end
        checkOutput("s5_reset_reached", found, 1);
        repeat (10) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("s5_restart_n", iss_log.size() > 0, 1);
        if (iss_log.size() > 0) checkOutput("s5_restart_addr", iss_log[0], 32'h0);

        // Long randomized run with occasional redirects and resets.
        startScenario(1, 2);
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                lat_min   = $urandom_range(3, 1);
                lat_extra = $urandom_range(3, 0);
            end
            applyStimulus($urandom_range(299, 0) != 0, $urandom_range(24, 0) == 0,
                          {20'h0, 10'($urandom_range(1023, 0)), 2'b00},
                          $urandom_range(3, 0) != 0, $urandom_range(9, 0) < 7);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
